junction_controller: RTL and testbench
======================================

Name: junction_controller

Overview:
Timing controller for a two-way road junction. It sequences two traffic-light sets, north-south (NS) and east-west (EW), each through red, red+amber, green, amber, with an all-red clearance between directions. It also serves a pedestrian-crossing request with a req/ack handshake and an all-red walk phase. The block sits above the single-set lights sequencer and drives the lamp outputs for both sets.

Parameters:
GREEN_TICKS, 8, cycles spent in green per direction
AMBER_TICKS, 2, cycles spent in amber per direction
RED_AMBER_TICKS, 2, cycles spent in red+amber per direction
ALL_RED_TICKS, 1, cycles of all-red clearance
PED_TICKS, 6, cycles of pedestrian walk
CNT_W, 4, dwell timer width; every *_TICKS must be in 1..2^CNT_W

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
enable  input  1  1 = sequence runs; 0 = state and timer freeze
ped_req  input  1  pedestrian request (level or pulse, sampled each cycle)
ped_ack  output  1  one-cycle pulse on the first cycle of the walk phase
walk  output  1  pedestrian walk lamp
ns_red  output  1  NS red lamp
ns_amber  output  1  NS amber lamp
ns_green  output  1  NS green lamp
ew_red  output  1  EW red lamp
ew_amber  output  1  EW amber lamp
ew_green  output  1  EW green lamp
phase  output  3  current state encoding: ALL_RED=0, RA=1, G=2, A=3, PED=4, FLASH=5

Behaviour:
- Single clock (clk); reset rst is asynchronous and active-high. All outputs are registered.
- State register: ALL_RED, RA, G, A, PED. A direction bit dir selects the active set (0 = NS, 1 = EW).
- Reset values:
  - state = ALL_RED, dir = NS, timer = ALL_RED_TICKS-1, pending = 0.
  - Outputs: ns_red = ew_red = 1, all ambers and greens = 0, walk = 0, ped_ack = 0, phase = 0.
- Dwell timer:
  - Loaded with TICKS-1 on entry to each state.
  - Decrements each enabled cycle.
  - State advances on the enabled cycle where timer == 0, so each state lasts exactly TICKS enabled cycles.
- Transitions:
  - ALL_RED -> PED if pending, else -> RA.
  - RA -> G -> A.
  - A -> ALL_RED, and dir toggles on that transition.
  - PED -> ALL_RED (second clearance), then RA for the current dir.
- Lamp outputs, inactive set always red only:
  - ALL_RED and PED: both sets red.
  - RA: active set red+amber.
  - G: active set green only.
  - A: active set amber only.
- Invariants:
  - At most one set is non-red at any time.
  - Illegal combinations never appear: none lit, red+green, amber+green.
  - walk = 1 only in PED.
- Pedestrian handshake:
  - pending sets on any cycle with ped_req = 1 (enable is ignored for sampling).
  - pending clears on the PED entry edge; ped_ack = 1 for exactly that first PED cycle.
  - ped_req asserted during PED re-sets pending. That request is served at the next ALL_RED that follows an A state, never at the clearance that follows PED. This guarantees at least one vehicle phase between walk phases.
  - Simultaneous clear and set on the PED entry edge: set wins, and the request is served next time.
- enable = 0:
  - Freezes state, timer, dir and all lamps.
  - ped_ack is held 0 and is emitted only when PED is actually entered.
- Full period without pedestrians (defaults): 2*(1+2+8+2) = 26 cycles.
- Reset mid-sequence returns immediately to the reset values; any pending request is lost.

Optional Feature:
NIGHT_FLASH_EN
- Defined:
  - Adds input port night (1 bit) and a FLASH state (phase = 5).
  - ALL_RED exit with night = 1 enters FLASH. Night has priority over pending; pending is held.
  - In FLASH: all reds and greens off, walk = 0, and both ambers toggle together every AMBER_TICKS cycles, starting on.
  - FLASH exits to ALL_RED at a toggle boundary where night = 0, with dir unchanged.
- Not defined: night port and FLASH state are absent, and phase never reads 5.

Test Plan:
- Reset, enable = 1, no requests, run 60 cycles:
  - phase sequence 0,1,2,3,0,1,2,3 with dwells 1,2,8,2; NS set first, then EW.
  - Period 26; lamp invariants checked every cycle.
- Pulse ped_req for 1 cycle during NS green:
  - After NS amber and ALL_RED, PED for 6 cycles with walk = 1.
  - ped_ack high only on PED cycle 1.
  - Then ALL_RED for 1 cycle, then EW RA.
- Hold ped_req high continuously:
  - PED occurs once per vehicle phase, never back to back.
  - Exactly one ped_ack per PED.
- Drop enable for 5 cycles mid-green:
  - Lamps and phase frozen.
  - Green lasts 8 enabled cycles total (13 wall cycles).
- Assert rst for 1 cycle during EW amber:
  - Outputs return to reset values immediately (asynchronously).
  - Sequence restarts with ALL_RED then NS.
- With NIGHT_FLASH_EN, assert night:
  - FLASH entered at the next ALL_RED exit; ambers toggle every 2 cycles.
  - Deassert night: FLASH exits to ALL_RED.

Source files
------------

// File: rtl/junction_controller.sv
// junction_controller: two-way junction timing controller (NS / EW light sets)
// with a pedestrian req/ack handshake and an all-red walk phase.
// Optional night flashing-amber mode is built when NIGHT_FLASH_EN is defined
// (adds the `night` input and the FLASH state, phase = 5).
module junction_controller #(
  parameter int unsigned GREEN_TICKS     = 8,
  parameter int unsigned AMBER_TICKS     = 2,
  parameter int unsigned RED_AMBER_TICKS = 2,
  parameter int unsigned ALL_RED_TICKS   = 1,
  parameter int unsigned PED_TICKS       = 6,
  parameter int unsigned CNT_W           = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       ped_req,
`ifdef NIGHT_FLASH_EN
  input  logic       night,
`endif
  output logic       ped_ack,
  output logic       walk,
  output logic       ns_red,
  output logic       ns_amber,
  output logic       ns_green,
  output logic       ew_red,
  output logic       ew_amber,
  output logic       ew_green,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    ST_ALL_RED = 3'd0,
    ST_RA      = 3'd1,
    ST_G       = 3'd2,
    ST_A       = 3'd3,
    ST_PED     = 3'd4
`ifdef NIGHT_FLASH_EN
    ,
    ST_FLASH   = 3'd5
`endif
  } state_t;

  localparam logic [CNT_W-1:0] T_GREEN   = CNT_W'(GREEN_TICKS - 1);
  localparam logic [CNT_W-1:0] T_AMBER   = CNT_W'(AMBER_TICKS - 1);
  localparam logic [CNT_W-1:0] T_RA      = CNT_W'(RED_AMBER_TICKS - 1);
  localparam logic [CNT_W-1:0] T_ALL_RED = CNT_W'(ALL_RED_TICKS - 1);
  localparam logic [CNT_W-1:0] T_PED     = CNT_W'(PED_TICKS - 1);

  state_t           state, state_n;
  logic             dir, dir_n;             // 0 = NS active, 1 = EW active
  logic [CNT_W-1:0] timer, timer_n;
  logic             pending, pending_n;
  logic             after_ped, after_ped_n; // this ALL_RED is the post-walk clearance
  logic             ack_n;
  logic             flash_on, flash_on_n;
  logic [2:0]       act_lamps;              // {red, amber, green} of the active set
  logic [2:0]       ns_n, ew_n;
  logic             walk_n;

  // Next-state, dwell timer and pedestrian request bookkeeping
  always_comb begin
    state_n     = state;
    dir_n       = dir;
    timer_n     = timer;
    after_ped_n = after_ped;
    flash_on_n  = flash_on;
    ack_n       = 1'b0;
    pending_n   = pending | ped_req;
    if (enable) begin
      if (timer != '0) begin
        timer_n = timer - CNT_W'(1);
      end else begin
        case (state)
          ST_ALL_RED: begin
            after_ped_n = 1'b0;
`ifdef NIGHT_FLASH_EN
            if (night) begin
              state_n    = ST_FLASH;
              timer_n    = T_AMBER;
              flash_on_n = 1'b1;
            end else
`endif
            // The clearance right after a walk never serves a new request,
            // so at least one vehicle phase separates two walk phases.
            if (pending && !after_ped) begin
              state_n   = ST_PED;
              timer_n   = T_PED;
              ack_n     = 1'b1;
              pending_n = ped_req;  // a request on the entry edge survives
            end else begin
              state_n = ST_RA;
              timer_n = T_RA;
            end
          end
          ST_RA: begin
            state_n = ST_G;
            timer_n = T_GREEN;
          end
          ST_G: begin
            state_n = ST_A;
            timer_n = T_AMBER;
          end
          ST_A: begin
            state_n = ST_ALL_RED;
            timer_n = T_ALL_RED;
            dir_n   = ~dir;
          end
          ST_PED: begin
            state_n     = ST_ALL_RED;
            timer_n     = T_ALL_RED;
            after_ped_n = 1'b1;
          end
`ifdef NIGHT_FLASH_EN
          ST_FLASH: begin
            timer_n = T_AMBER;
            if (!night) begin
              state_n    = ST_ALL_RED;
              timer_n    = T_ALL_RED;
              flash_on_n = 1'b0;
            end else begin
              flash_on_n = ~flash_on;
            end
          end
`endif
          default: begin
            state_n = ST_ALL_RED;
            timer_n = T_ALL_RED;
          end
        endcase
      end
    end
  end

  // Lamp decode from the next state so the lamp registers track the state register
  always_comb begin
    case (state_n)
      ST_RA:   act_lamps = 3'b110;
      ST_G:    act_lamps = 3'b001;
      ST_A:    act_lamps = 3'b010;
      default: act_lamps = 3'b100;
    endcase
    ns_n   = 3'b100;
    ew_n   = 3'b100;
    walk_n = (state_n == ST_PED);
    if (state_n == ST_RA || state_n == ST_G || state_n == ST_A) begin
      if (dir_n) ew_n = act_lamps;
      else       ns_n = act_lamps;
    end
`ifdef NIGHT_FLASH_EN
    if (state_n == ST_FLASH) begin
      ns_n = {1'b0, flash_on_n, 1'b0};
      ew_n = {1'b0, flash_on_n, 1'b0};
    end
`endif
  end

  // State, timer and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_ALL_RED;
      dir       <= 1'b0;
      timer     <= T_ALL_RED;
      pending   <= 1'b0;
      after_ped <= 1'b0;
      flash_on  <= 1'b0;
      ped_ack   <= 1'b0;
      walk      <= 1'b0;
      ns_red    <= 1'b1;
      ns_amber  <= 1'b0;
      ns_green  <= 1'b0;
      ew_red    <= 1'b1;
      ew_amber  <= 1'b0;
      ew_green  <= 1'b0;
      phase     <= 3'd0;
    end else begin
      state     <= state_n;
      dir       <= dir_n;
      timer     <= timer_n;
      pending   <= pending_n;
      after_ped <= after_ped_n;
      flash_on  <= flash_on_n;
      ped_ack   <= ack_n;
      walk      <= walk_n;
      {ns_red, ns_amber, ns_green} <= ns_n;
      {ew_red, ew_amber, ew_green} <= ew_n;
      phase     <= state_n;
    end
  end

endmodule

// File: tb/tb_junction_controller.sv
// Self-checking bench for junction_controller: a cycle model pushes expected
// output vectors into a scoreboard queue as stimulus is driven; they are popped
// and compared after each clock edge. Define NIGHT_FLASH_EN to cover FLASH.
module tb_junction_controller;

  localparam int G_T = 8, A_T = 2, RA_T = 2, AR_T = 1, P_T = 6;

  logic       clk = 1'b0;
  logic       rst, enable, ped_req;
  logic       night_i = 1'b0;
  logic       ped_ack, walk, ns_red, ns_amber, ns_green, ew_red, ew_amber, ew_green;
  logic [2:0] phase;

  junction_controller #(
    .GREEN_TICKS(G_T), .AMBER_TICKS(A_T), .RED_AMBER_TICKS(RA_T),
    .ALL_RED_TICKS(AR_T), .PED_TICKS(P_T), .CNT_W(4)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .ped_req(ped_req),
`ifdef NIGHT_FLASH_EN
    .night(night_i),
`endif
    .ped_ack(ped_ack), .walk(walk),
    .ns_red(ns_red), .ns_amber(ns_amber), .ns_green(ns_green),
    .ew_red(ew_red), .ew_amber(ew_amber), .ew_green(ew_green),
    .phase(phase)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0;
  int cyc = 0;
  logic [10:0] exp_q[$];

  // reference model
  int m_st, m_cnt;
  bit m_dir, m_pend, m_after, m_fl, m_ack;

  // observation statistics
  int   acks, ped_entries, walk_cnt, flash_cnt, gcount;
  bit   green_seen;
  logic [2:0] prev_phase = 3'd0;
  int   ns_ra_starts[$];

  localparam logic [10:0] RESET_V = {3'd0, 3'b100, 3'b100, 1'b0, 1'b0};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [10:0] outs();
    return {phase, ns_red, ns_amber, ns_green, ew_red, ew_amber, ew_green, walk, ped_ack};
  endfunction

  function automatic int dwell(input int st);
    case (st)
      0: return AR_T;
      1: return RA_T;
      2: return G_T;
      3: return A_T;
      4: return P_T;
      default: return A_T;
    endcase
  endfunction

  function automatic logic [10:0] expv(input int st, input bit d, input bit fl, input bit ack);
    logic [2:0] act, ns, ew;
    case (st)
      1: act = 3'b110;
      2: act = 3'b001;
      3: act = 3'b010;
      default: act = 3'b100;
    endcase
    ns = 3'b100;
    ew = 3'b100;
    if (st inside {1, 2, 3}) begin
      if (d) ew = act;
      else   ns = act;
    end
    if (st == 5) begin
      ns = {1'b0, fl, 1'b0};
      ew = ns;
    end
    return {3'(st), ns, ew, (st == 4), ack};
  endfunction

  task automatic model_reset();
    m_st = 0; m_cnt = 0; m_dir = 0; m_pend = 0; m_after = 0; m_fl = 0; m_ack = 0;
  endtask

  task automatic model_edge(input logic en, input logic req);
    bit np;
    np = m_pend | req;
    m_ack = 0;
    if (en) begin
      if (m_cnt + 1 < dwell(m_st)) m_cnt++;
      else begin
        m_cnt = 0;
        case (m_st)
          0: begin
            if (night_i) begin m_st = 5; m_fl = 1; end
            else if (m_pend && !m_after) begin m_st = 4; m_ack = 1; np = req; end
            else m_st = 1;
            m_after = 0;
          end
          1: m_st = 2;
          2: m_st = 3;
          3: begin m_st = 0; m_dir = !m_dir; end
          4: begin m_st = 0; m_after = 1; end
          default: begin
            if (!night_i) begin m_st = 0; m_fl = 0; end
            else m_fl = !m_fl;
          end
        endcase
      end
    end
    m_pend = np;
  endtask

  task automatic step(input logic en, input logic req);
    logic [10:0] got, e;
    logic ok;
    @(negedge clk);
    enable  = en;
    ped_req = req;
    model_edge(en, req);
    exp_q.push_back(expv(m_st, m_dir, m_fl, m_ack));
    @(posedge clk);
    #1;
    cyc++;
    got = outs();
    e = exp_q.pop_front();
    check("outputs", 32'(got), 32'(e));
    ok = (phase == 3'd5) ||
         (!((ns_amber | ns_green) && (ew_amber | ew_green)) &&
          (ns_red | ns_amber | ns_green) && !(ns_red & ns_green) && !(ns_amber & ns_green) &&
          (ew_red | ew_amber | ew_green) && !(ew_red & ew_green) && !(ew_amber & ew_green) &&
          (walk == (phase == 3'd4)));
    check("lamp_invariant", 32'(ok), 32'd1);
    if (ped_ack) acks++;
    if (walk) walk_cnt++;
    if (phase == 3'd5) flash_cnt++;
    if (phase == 3'd2) green_seen = 1;
    if (phase == 3'd4 && prev_phase != 3'd4) begin
      if (ped_entries > 0) check("vehicle_phase_between_walks", 32'(green_seen), 32'd1);
      ped_entries++;
      green_seen = 0;
    end
    if (phase == 3'd1 && prev_phase != 3'd1 && ns_amber) ns_ra_starts.push_back(cyc);
    prev_phase = phase;
  endtask

  task automatic reset_midcycle();
    #2 rst = 1'b1;
    #1 check("async_reset", 32'(outs()), 32'(RESET_V));
    enable  = 1'b0;
    ped_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    prev_phase = 3'd0;
  endtask

  initial begin
    bit reached;
    rst = 1'b1; enable = 1'b0; ped_req = 1'b0;
    model_reset();
    #12;
    @(negedge clk);
    rst = 1'b0;
    #1 check("reset_state", 32'(outs()), 32'(RESET_V));

    // free run, no pedestrians: full period is 26 cycles
    ns_ra_starts.delete();
    for (int i = 0; i < 60; i++) step(1'b1, 1'b0);
    check("ns_ra_count", 32'(ns_ra_starts.size() >= 2), 32'd1);
    if (ns_ra_starts.size() >= 2)
      check("period", 32'(ns_ra_starts[1] - ns_ra_starts[0]), 32'd26);

    // single request pulse during NS green
    reached = 0;
    for (int i = 0; i < 60 && !reached; i++) begin
      step(1'b1, 1'b0);
      reached = (m_st == 2 && m_dir == 0);
    end
    check("reach_ns_green", 32'(reached), 32'd1);
    acks = 0; walk_cnt = 0;
    step(1'b1, 1'b1);
    for (int i = 0; i < 30; i++) step(1'b1, 1'b0);
    check("pulse_ack_count", 32'(acks), 32'd1);
    check("pulse_walk_cycles", 32'(walk_cnt), 32'(P_T));

    // request held continuously
    acks = 0; ped_entries = 0; green_seen = 0;
    for (int i = 0; i < 80; i++) step(1'b1, 1'b1);
    check("held_ack_per_ped", 32'(acks), 32'(ped_entries));
    check("held_ped_entries", 32'(ped_entries >= 3), 32'd1);

    // enable dropped for 5 cycles mid NS green
    reached = 0;
    for (int i = 0; i < 80 && !reached; i++) begin
      step(1'b1, 1'b0);
      reached = (m_st == 2 && m_cnt == 0 && m_dir == 0);
    end
    check("reach_green_entry", 32'(reached), 32'd1);
    gcount = 1;
    for (int i = 0; i < 2; i++) begin step(1'b1, 1'b0); if (ns_green) gcount++; end
    for (int i = 0; i < 5; i++) begin step(1'b0, 1'b0); if (ns_green) gcount++; end
    for (int i = 0; i < 20 && ns_green; i++) begin step(1'b1, 1'b0); if (ns_green) gcount++; end
    check("green_wall_cycles", 32'(gcount), 32'd13);

    // reset during EW amber
    reached = 0;
    for (int i = 0; i < 80 && !reached; i++) begin
      step(1'b1, 1'b0);
      reached = (m_st == 3 && m_dir == 1);
    end
    check("reach_ew_amber", 32'(reached), 32'd1);
    reset_midcycle();
    for (int i = 0; i < 30; i++) step(1'b1, 1'b0);

`ifdef NIGHT_FLASH_EN
    night_i = 1'b1;
    flash_cnt = 0;
    for (int i = 0; i < 40; i++) step(1'b1, 1'b0);
    check("flash_entered", 32'(flash_cnt > 0), 32'd1);
    night_i = 1'b0;
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0);
    check("flash_exited", 32'(phase != 3'd5), 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog timeout got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
